// File: rtl/cpu_defs.sv
// Shared CPU definitions: memory access sizes, MEM-stage FSM states and
// the lane helpers used to build byte enables and store data.
package cpu_defs;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mas_state_t;

    // Little-endian byte enables; the reserved size behaves as a word.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MEM_SIZE_BYTE: lane_be = 4'b0001 << off;
            MEM_SIZE_HALF: lane_be = 4'b0011 << off;
            default:       lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] data);
        case (size)
            MEM_SIZE_BYTE: lane_rep = {4{data[7:0]}};
            MEM_SIZE_HALF: lane_rep = {2{data[15:0]}};
            default:       lane_rep = data;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed lane of a read word and sign/zero-extends it.
// Purely combinational so writeback forwarding can reuse it.
module load_align
    import cpu_defs::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by extension according to size.
    always_comb begin
        byte_s = rdata[8*lane +: 8];
        half_s = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            MEM_SIZE_BYTE: data = {{24{byte_s[7] & ~is_unsigned}}, byte_s};
            MEM_SIZE_HALF: data = {{16{half_s[15] & ~is_unsigned}}, half_s};
            default:       data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory controller: issues one req/ack bus transaction per
// aligned load/store, stalls the upstream pipe meanwhile, aligns load data.
module mem_access_stage
    import cpu_defs::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              stall,
    output logic              out_valid,
    output logic [31:0]       load_data,
    output logic              addr_err,
    output logic              bus_err
);

    localparam logic [7:0] TO_LAST_C = 8'(TIMEOUT - 1);

    mas_state_t  state_r;
    logic [7:0]  cnt_r;
    logic [1:0]  size_r;
    logic [1:0]  lane_r;
    logic        unsigned_r;
    logic        load_r;
    logic        mem_op_s;
    logic        misalign_s;
    logic        issue_s;
    logic [31:0] aligned_s;

    load_align u_load_align (
        .rdata       (dmem_rdata),
        .lane        (lane_r),
        .size        (size_r),
        .is_unsigned (unsigned_r),
        .data        (aligned_s)
    );

    // Decode the EX/MEM instruction: memory op, misalignment, issue.
    always_comb begin
        mem_op_s = in_valid & (mem_read | mem_write);
        case (mem_size)
            MEM_SIZE_BYTE: misalign_s = 1'b0;
            MEM_SIZE_HALF: misalign_s = addr[0];
            default:       misalign_s = (addr[1:0] != 2'b00);
        endcase
        issue_s = (state_r == IDLE) & mem_op_s & ~misalign_s;
    end

    // Pipeline handshake outputs; forced low while reset is asserted.
    always_comb begin
        stall     = 1'b0;
        out_valid = 1'b0;
        addr_err  = 1'b0;
        if (!rst) begin
            stall     = 1'b0;
            out_valid = 1'b0;
            addr_err  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    stall     = issue_s;
                    out_valid = in_valid & ~issue_s;
                    addr_err  = mem_op_s & misalign_s;
                end
                BUSY:    stall     = 1'b1;
                DONE:    out_valid = 1'b1;
                default: stall     = 1'b0;
            endcase
        end
    end

    // Transaction FSM with latched bus fields, load result and timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            cnt_r      <= 8'd0;
            size_r     <= 2'd0;
            lane_r     <= 2'd0;
            unsigned_r <= 1'b0;
            load_r     <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            load_data  <= 32'd0;
            bus_err    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (issue_s) begin
                        state_r    <= BUSY;
                        cnt_r      <= 8'd0;
                        size_r     <= mem_size;
                        lane_r     <= addr[1:0];
                        unsigned_r <= mem_unsigned;
                        // A simultaneous read+write is executed as a store.
                        load_r     <= mem_read & ~mem_write;
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write;
                        dmem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        dmem_be    <= lane_be(mem_size, addr[1:0]);
                        dmem_wdata <= lane_rep(mem_size, wdata);
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        state_r  <= DONE;
                        if (load_r) begin
                            load_data <= aligned_s;
                        end else begin
                            load_data <= load_data;
                        end
                    end else if (cnt_r == TO_LAST_C) begin
                        dmem_req <= 1'b0;
                        bus_err  <= 1'b1;
                        state_r  <= DONE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    bus_err <= 1'b0;
                end
                default: begin
                    state_r  <= IDLE;
                    dmem_req <= 1'b0;
                    bus_err  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage with a delayed-ack memory responder.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, mem_unsigned = 1'b0;
    logic [1:0]  mem_size = 2'd0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'd0;
    logic [3:0]  dmem_be;
    logic        stall, out_valid, addr_err, bus_err;
    logic [31:0] load_data;

    int checks = 0;
    int failures = 0;
    int ack_delay = 0;
    logic [31:0] rdata_val = 32'd0;

    typedef struct {
        logic [31:0] ld;
        logic        chk_ld;
        logic        aerr;
        logic        berr;
        int          stalls;
        logic        bus;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] bwd;
    } exp_t;

    exp_t sb_q[$];

    mem_access_stage #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read(mem_read),
        .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .addr(addr), .wdata(wdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
        .out_valid(out_valid), .load_data(load_data), .addr_err(addr_err),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Memory responder: ack in the ack_delay-th cycle of a request (0 = never).
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (dmem_req && !dmem_ack && ack_delay != 0) begin
                wait_cnt = wait_cnt + 1;
                if (wait_cnt == ack_delay) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata_val;
                end
            end else begin
                dmem_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [31:0] ld, input logic chk_ld, input logic aerr,
                                    input logic berr, input int stalls, input logic bus,
                                    input logic [31:0] baddr, input logic [3:0] be,
                                    input logic we, input logic [31:0] bwd);
        exp_t e;
        e.ld = ld; e.chk_ld = chk_ld; e.aerr = aerr; e.berr = berr; e.stalls = stalls;
        e.bus = bus; e.baddr = baddr; e.be = be; e.we = we; e.bwd = bwd;
        return e;
    endfunction

    // Drive one instruction (called at posedge+1), hold it until out_valid.
    task automatic run_op(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd,
                          input int dly, input logic [31:0] rdv, input exp_t e);
        int   stalls;
        logic saw_req;
        logic done;
        exp_t x;
        sb_q.push_back(e);
        ack_delay = dly; rdata_val = rdv;
        in_valid = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz;
        mem_unsigned = uns; addr = a; wdata = wd;
        stalls = 0; saw_req = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (dmem_req && !saw_req) begin
                saw_req = 1'b1;
                check_val({tag, "_addr"}, dmem_addr, sb_q[0].baddr);
                check_val({tag, "_be"}, {28'd0, dmem_be}, {28'd0, sb_q[0].be});
                check_val({tag, "_we"}, {31'd0, dmem_we}, {31'd0, sb_q[0].we});
                if (sb_q[0].we) check_val({tag, "_wdata"}, dmem_wdata, sb_q[0].bwd);
            end
            if (out_valid) begin
                x = sb_q.pop_front();
                done = 1'b1;
                check_val({tag, "_addr_err"}, {31'd0, addr_err}, {31'd0, x.aerr});
                check_val({tag, "_bus_err"}, {31'd0, bus_err}, {31'd0, x.berr});
                check_val({tag, "_stalls"}, stalls, x.stalls);
                check_val({tag, "_bus_used"}, {31'd0, saw_req}, {31'd0, x.bus});
                if (x.chk_ld) check_val({tag, "_load_data"}, load_data, x.ld);
            end
            @(posedge clk); #1;
        end
        if (!done) check_val({tag, "_out_valid_timeout"}, 32'd0, 32'd1);
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        check_val({tag, "_post_req"}, {31'd0, dmem_req}, 32'd0);
        check_val({tag, "_post_bus_err"}, {31'd0, bus_err}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_req", {31'd0, dmem_req}, 32'd0);
        check_val("rst_stall", {31'd0, stall}, 32'd0);
        check_val("rst_load_data", load_data, 32'd0);
        check_val("rst_be", {28'd0, dmem_be}, 32'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        run_op("nop", 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, 32'h0,
               mk_exp(32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0));
        run_op("lw", 1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF,
               mk_exp(32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 4, 1'b1, 32'h100, 4'b1111, 1'b0, 32'h0));
        run_op("lb", 1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1, 32'h80FF0000,
               mk_exp(32'hFFFFFF80, 1'b1, 1'b0, 1'b0, 2, 1'b1, 32'h100, 4'b1000, 1'b0, 32'h0));
        run_op("lbu", 1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 2, 32'h80FF0000,
               mk_exp(32'h00000080, 1'b1, 1'b0, 1'b0, 3, 1'b1, 32'h100, 4'b1000, 1'b0, 32'h0));
        run_op("sh", 1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h1234ABCD, 1, 32'h0,
               mk_exp(32'h00000080, 1'b1, 1'b0, 1'b0, 2, 1'b1, 32'h200, 4'b1100, 1'b1, 32'hABCDABCD));
        run_op("lw_mis", 1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 1, 32'h0,
               mk_exp(32'h0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0));
        run_op("sh_mis", 1'b0, 1'b1, 2'd1, 1'b0, 32'h203, 32'h0, 1, 32'h0,
               mk_exp(32'h0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0));
        run_op("lh", 1'b1, 1'b0, 2'd1, 1'b0, 32'h106, 32'h0, 2, 32'h80011234,
               mk_exp(32'hFFFF8001, 1'b1, 1'b0, 1'b0, 3, 1'b1, 32'h104, 4'b1100, 1'b0, 32'h0));
        run_op("sb_rw", 1'b1, 1'b1, 2'd0, 1'b0, 32'h101, 32'h0000005A, 1, 32'h11111111,
               mk_exp(32'hFFFF8001, 1'b1, 1'b0, 1'b0, 2, 1'b1, 32'h100, 4'b0010, 1'b1, 32'h5A5A5A5A));
        run_op("lw_timeout", 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 32'h0,
               mk_exp(32'hFFFF8001, 1'b1, 1'b0, 1'b1, 5, 1'b1, 32'h10, 4'b1111, 1'b0, 32'h0));
        run_op("lw_ack_at_to", 1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 4, 32'h0BADF00D,
               mk_exp(32'h0BADF00D, 1'b1, 1'b0, 1'b0, 5, 1'b1, 32'h20, 4'b1111, 1'b0, 32'h0));

        // Reset in the middle of a stalled load, with the instruction still live.
        ack_delay = 0;
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'd2; addr = 32'h400;
        repeat (3) @(negedge clk);
        check_val("mid_busy_req", {31'd0, dmem_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check_val("async_rst_req", {31'd0, dmem_req}, 32'd0);
        check_val("async_rst_stall", {31'd0, stall}, 32'd0);
        check_val("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0; mem_read = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        run_op("sw_after_rst", 1'b0, 1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFEF00D, 2, 32'h0,
               mk_exp(32'h0, 1'b1, 1'b0, 1'b0, 3, 1'b1, 32'h300, 4'b1111, 1'b1, 32'hCAFEF00D));

        check_val("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage data-memory controller. Consumes the EX/MEM pipeline register outputs and runs a req/ack transaction on the data-memory bus.
- Aligns and sign-extends load data, and raises a stall that freezes PC/IF_ID/ID_EX/EX_MEM while a transaction is outstanding.
- Feeds MEM_WB with load_data, out_valid and error flags.

Parameters:
- ADDR_W, 32, data-bus address width.
- TIMEOUT, 255, cycles BUSY may wait for dmem_ack before aborting with bus_err (8-bit counter; 1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM holds a live instruction (0 = bubble).
- mem_read  in  1  load.
- mem_write  in  1  store.
- mem_size  in  2  0 byte, 1 half, 2 word, 3 reserved (treated as word).
- mem_unsigned  in  1  zero-extend load (lbu/lhu).
- addr  in  ADDR_W  effective address (alu_res_out).
- wdata  in  32  store data (sw_data_out).
- dmem_req  out  1  bus request, held until ack.
- dmem_we  out  1  write strobe, valid with dmem_req.
- dmem_addr  out  ADDR_W  word-aligned address (addr[1:0] forced 0).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  one-cycle completion pulse.
- dmem_rdata  in  32  read word, valid with ack.
- stall  out  1  hold upstream stages; drives EX_MEM we low.
- out_valid  out  1  result for MEM_WB this cycle.
- load_data  out  32  aligned, extended load result.
- addr_err  out  1  misaligned access; no bus cycle issued.
- bus_err  out  1  timeout abort.

Behaviour:
- Reset (rst=0, async): state IDLE; dmem_req, dmem_we, dmem_be, stall, out_valid, addr_err, bus_err = 0; dmem_addr, dmem_wdata, load_data, timeout counter = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no memory op (in_valid=0, or rd=wr=0):
  - out_valid = in_valid, combinational pass-through.
  - stall = 0.
- IDLE, memory op, misaligned (half with addr[0]=1, or word with addr[1:0]!=0):
  - out_valid = 1, addr_err = 1 combinationally; no request; stay IDLE.
- IDLE, memory op, aligned:
  - stall = 1 combinationally.
  - Latch dmem_addr/be/we/wdata, size and sign; go to BUSY with dmem_req = 1 from the next cycle.
  - mem_read and mem_write both 1: treated as a store.
- Lanes (little-endian): byte k occupies bits [8k+7:8k].
  - Byte: be = 1 << addr[1:0].
  - Half: be = 4'b0011 << addr[1:0].
  - Word: be = 4'b1111.
  - Store data: sb = {4{wdata[7:0]}}, sh = {2{wdata[15:0]}}, sw = wdata.
- BUSY:
  - dmem_req and the latched bus fields are held stable; stall = 1; counter increments each cycle.
  - dmem_ack: drop req; on a load, register the selected lane (sign- or zero-extended) into load_data; go to DONE.
  - Counter reaches TIMEOUT without ack: drop req, set bus_err, go to DONE.
  - ack in the same cycle as the timeout wins: no bus_err.
- DONE (exactly one cycle):
  - stall = 0, out_valid = 1; bus_err shown if set; load_data held until the next load completes.
  - EX_MEM advances at the end of this cycle. The still-visible old instruction is not re-accepted.
  - Next state IDLE; bus_err cleared on exit.
- Latency: load/store = 1 (issue) + N (ack wait, N ≥ 1) + 1 (DONE) cycles. Non-memory ops have 0 added latency.
- dmem_ack outside BUSY: ignored.
- Reset mid-BUSY: req drops immediately (async); the transaction is abandoned. The memory model must tolerate this.

Decomposition:
- Shared package (cpu_defs):
  - MEM_SIZE_BYTE/HALF/WORD encodings.
  - State encodings IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2.
  - Default TIMEOUT.
- One natural sub-module, load_align: combinational rdata + addr[1:0] + size + unsigned -> load_data. Reused by the writeback forwarding logic.

Test Plan:
- lw at 0x100, ack 3 cycles after req, rdata 0xDEADBEEF -> be = 1111, stall high 4 cycles, out_valid in DONE, load_data = 0xDEADBEEF.
- lb at 0x103, rdata 0x80FF_0000 -> be = 1000, load_data = 0xFFFFFF80; lbu same -> 0x00000080.
- sh at 0x202, wdata 0x1234ABCD -> dmem_addr = 0x200, be = 1100, dmem_wdata = 0xABCDABCD, dmem_we = 1.
- lw at 0x101 -> no dmem_req, addr_err = 1 and out_valid = 1 same cycle, stall = 0.
- TIMEOUT = 4, no ack -> req drops after 4 BUSY cycles, bus_err = 1 in DONE. Repeat with ack on cycle 4 -> bus_err = 0.
- rst low while BUSY -> dmem_req and stall go 0 without a clock edge; after release a new sw completes normally.
